// File: rtl/rx_pkg.sv
// Shared receive-path definitions: header layout constants and parser states.
// Used by rx_seg_parser and other rx stages.
package rx_pkg;

   localparam int SEG_POS_DEF = 5;
   localparam int HDR_LEN_DEF = 11;

   localparam int SEG_HI_OFS = 0;
   localparam int SEG_LO_OFS = 1;
   localparam int ID_OFS     = 2;
   localparam int AUX_OFS    = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_END,
      ST_DROP
   } rx_state_e;

endpackage

// File: rtl/rx_byte_ctr.sv
// Frame-relative byte counter; saturates at all-ones, never wraps.
// Clearing together with a count loads 1 (the start byte itself).
module rx_byte_ctr #(
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [LEN_W-1:0] o_cnt
);

   localparam logic [LEN_W-1:0] L_MAX = '1;
   localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

   logic [LEN_W-1:0] r_cnt;

   // count accepted bytes, restarting on frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= i_en ? L_ONE : '0;
      end else if (i_en && (r_cnt != L_MAX)) begin
         r_cnt <= r_cnt + L_ONE;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/rx_seg_parser.sv
// Segment header parser: extracts seg/id/aux, forwards payload, reports per frame.
// Optional macro RX_SEG_SEQ_CHECK_EN adds the seq_err segment-continuity output.
module rx_seg_parser
   import rx_pkg::*;
#(
   parameter int SEG_POS = SEG_POS_DEF,
   parameter int HDR_LEN = HDR_LEN_DEF,
   parameter int LEN_W   = 11
) (
   input  logic             rx_clk,
   input  logic             rst_n,
   input  logic [7:0]       rawdata,
   input  logic             raw_en,
`ifdef RX_SEG_SEQ_CHECK_EN
   output logic             seq_err,
`endif
   output logic [7:0]       payload_data,
   output logic             payload_en,
   output logic [15:0]      seg_num,
   output logic [7:0]       seg_id,
   output logic [7:0]       seg_aux,
   output logic [LEN_W-1:0] payload_len,
   output logic             hdr_valid,
   output logic             frame_err
);

   localparam logic [LEN_W-1:0] L_SEG_HI = LEN_W'(SEG_POS + SEG_HI_OFS);
   localparam logic [LEN_W-1:0] L_SEG_LO = LEN_W'(SEG_POS + SEG_LO_OFS);
   localparam logic [LEN_W-1:0] L_ID     = LEN_W'(SEG_POS + ID_OFS);
   localparam logic [LEN_W-1:0] L_AUX    = LEN_W'(SEG_POS + AUX_OFS);
   localparam logic [LEN_W-1:0] L_HDR    = LEN_W'(HDR_LEN);
   localparam logic [LEN_W-1:0] L_HDR_LS = LEN_W'(HDR_LEN - 1);

   rx_state_e        r_state;
   logic             r_first;
   logic [7:0]       r_sh_hi;
   logic [7:0]       r_sh_lo;
   logic [7:0]       r_sh_id;
   logic [7:0]       r_sh_aux;
`ifdef RX_SEG_SEQ_CHECK_EN
   logic [15:0]      r_exp;
   logic             r_seen;
`endif

   logic             w_start;
   logic             w_cnt_en;
   logic             w_cap;
   logic             w_good;
   logic [LEN_W-1:0] w_cnt;
   logic [LEN_W-1:0] w_idx;
   logic [15:0]      w_seg;

   // a frame may start in IDLE (except the first cycle after reset) or END
   assign w_start  = raw_en &
                     (((r_state == ST_IDLE) & ~r_first) |
                      (r_state == ST_END));
   assign w_cnt_en = w_start |
                     (raw_en & ((r_state == ST_HDR) |
                                (r_state == ST_PAYLOAD)));
   assign w_idx    = w_start ? '0 : w_cnt;
   assign w_cap    = raw_en & (w_start | (r_state == ST_HDR));
   assign w_good   = (r_state == ST_PAYLOAD) | (w_cnt >= L_HDR);
   assign w_seg    = {r_sh_hi, r_sh_lo};

   rx_byte_ctr #(
      .LEN_W (LEN_W)
   ) u_ctr (
      .clk   (rx_clk),
      .rst_n (rst_n),
      .i_clr (w_start),
      .i_en  (w_cnt_en),
      .o_cnt (w_cnt)
   );

   // frame state machine, header capture and registered outputs
   always_ff @(posedge rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_first      <= 1'b1;
         r_sh_hi      <= '0;
         r_sh_lo      <= '0;
         r_sh_id      <= '0;
         r_sh_aux     <= '0;
         payload_data <= '0;
         payload_en   <= 1'b0;
         seg_num      <= '0;
         seg_id       <= '0;
         seg_aux      <= '0;
         payload_len  <= '0;
         hdr_valid    <= 1'b0;
         frame_err    <= 1'b0;
`ifdef RX_SEG_SEQ_CHECK_EN
         seq_err      <= 1'b0;
         r_exp        <= '0;
         r_seen       <= 1'b0;
`endif
      end else begin
         r_first    <= 1'b0;
         payload_en <= 1'b0;
         hdr_valid  <= 1'b0;
         frame_err  <= 1'b0;
`ifdef RX_SEG_SEQ_CHECK_EN
         seq_err    <= 1'b0;
`endif
         if (w_cap) begin
            if (w_idx == L_SEG_HI) r_sh_hi  <= rawdata;
            if (w_idx == L_SEG_LO) r_sh_lo  <= rawdata;
            if (w_idx == L_ID)     r_sh_id  <= rawdata;
            if (w_idx == L_AUX)    r_sh_aux <= rawdata;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (raw_en) r_state <= r_first ? ST_DROP : ST_HDR;
            end
            ST_HDR, ST_PAYLOAD: begin
               if (!raw_en) begin
                  r_state <= ST_END;
                  if (w_good) begin
                     seg_num     <= w_seg;
                     seg_id      <= r_sh_id;
                     seg_aux     <= r_sh_aux;
                     payload_len <= w_cnt - L_HDR;
                     hdr_valid   <= 1'b1;
`ifdef RX_SEG_SEQ_CHECK_EN
                     seq_err     <= r_seen & (w_seg != r_exp);
                     r_exp       <= w_seg + 16'd1;
                     r_seen      <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (r_state == ST_PAYLOAD) begin
                  payload_data <= rawdata;
                  payload_en   <= 1'b1;
               end else if (w_idx == L_HDR_LS) begin
                  r_state <= ST_PAYLOAD;
               end
            end
            ST_END: begin
               r_state <= raw_en ? ST_HDR : ST_IDLE;
            end
            ST_DROP: begin
               if (!raw_en) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
